// File: rtl/tlul_host_arb2.sv
// -----------------------------------------------------------------------------
// tlul_host_arb2 -- 2:1 TL-UL host arbiter
//
// Merges the core's data host (host 0) and instruction host (host 1) onto a
// single TL-UL device port. A-channel arbitration is combinational with grant
// locking while the device stalls; the winner's index is placed in the top bit
// of a_source and used to route D-channel responses back. Per-host outstanding
// counters enforce MaxOutstanding and flag responses nobody is waiting for.
//
// Optional feature: define TLUL_ARB_RR_EN for round-robin arbitration
// (default build: fixed priority, host 0 over host 1).
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   tl_h0_i  in   host 0 (data) request          tl_h0_o  out  host 0 response
//   tl_h1_i  in   host 1 (instr) request         tl_h1_o  out  host 1 response
//   tl_d_o   out  device-side request            tl_d_i   in   device-side response
//   busy_o   out  any host has outstanding transactions
//   err_o    out  sticky: response for a host with nothing outstanding
// -----------------------------------------------------------------------------

package tlul_pkg;
    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_AIW = 8;
    parameter int TL_DIW = 1;
    parameter int TL_SZW = 2;
    parameter int TL_DBW = TL_DW / 8;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb2
    import tlul_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int SrcW           = TL_AIW
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h0_i,
    output tl_d2h_t tl_h0_o,
    input  tl_h2d_t tl_h1_i,
    output tl_d2h_t tl_h1_o,
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    busy_o,
    output logic    err_o
);

    localparam int              CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            r_lock;
    logic            r_sel;
    logic [CntW-1:0] r_cnt0;
    logic [CntW-1:0] r_cnt1;
    logic            r_err;
`ifdef TLUL_ARB_RR_EN
    logic            r_rr_ptr;
`endif

    logic    w_elig0, w_elig1;
    logic    w_sel, w_fwd;
    logic    w_a_fire0, w_a_fire1;
    logic    w_dtgt;
    logic    w_d_fire0, w_d_fire1;
    tl_h2d_t w_req;

    // A host at its outstanding limit is invisible to arbitration.
    assign w_elig0 = tl_h0_i.a_valid && (r_cnt0 < MaxCnt);
    assign w_elig1 = tl_h1_i.a_valid && (r_cnt1 < MaxCnt);

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_sel;
        end
`ifdef TLUL_ARB_RR_EN
        else if (w_elig0 && w_elig1) begin
            w_sel = r_rr_ptr;
        end else begin
            w_sel = w_elig1;    // sole eligible host wins; 0 when idle
        end
`else
        else begin
            w_sel = ~w_elig0 & w_elig1;
        end
`endif
    end

    // While locked, a host that dropped a_valid forwards nothing.
    assign w_fwd = w_sel ? w_elig1 : w_elig0;
    assign w_req = w_sel ? tl_h1_i : tl_h0_i;

    assign w_a_fire0 = tl_d_i.a_ready & ~w_sel & w_elig0;
    assign w_a_fire1 = tl_d_i.a_ready &  w_sel & w_elig1;

    // Responses are steered by the tag the arbiter put in a_source.
    assign w_dtgt    = tl_d_i.d_source[SrcW-1];
    assign w_d_fire0 = tl_d_i.d_valid & ~w_dtgt & tl_h0_i.d_ready;
    assign w_d_fire1 = tl_d_i.d_valid &  w_dtgt & tl_h1_i.d_ready;

    always_comb begin
        tl_d_o          = w_req;
        tl_d_o.a_valid  = w_fwd;
        tl_d_o.a_source = {w_sel, w_req.a_source[SrcW-2:0]};
        tl_d_o.d_ready  = w_dtgt ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    end

    always_comb begin
        tl_h0_o          = tl_d_i;
        tl_h0_o.d_valid  = tl_d_i.d_valid & ~w_dtgt;
        tl_h0_o.d_source = {1'b0, tl_d_i.d_source[SrcW-2:0]};
        tl_h0_o.a_ready  = w_a_fire0;

        tl_h1_o          = tl_d_i;
        tl_h1_o.d_valid  = tl_d_i.d_valid & w_dtgt;
        tl_h1_o.d_source = {1'b0, tl_d_i.d_source[SrcW-2:0]};
        tl_h1_o.a_ready  = w_a_fire1;
    end

    // A response with nothing outstanding is ignored (no underflow); a request
    // firing in the same cycle still counts.
    function automatic logic [CntW-1:0] f_cnt_next(input logic [CntW-1:0] cnt,
                                                   input logic a_fire,
                                                   input logic d_fire);
        logic dec;
        logic [CntW-1:0] nxt;
        dec = d_fire && (cnt != '0);
        nxt = cnt;
        if (a_fire && !dec) begin
            nxt = cnt + CntW'(1);
        end else if (!a_fire && dec) begin
            nxt = cnt - CntW'(1);
        end
        return nxt;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock <= 1'b0;
            r_sel  <= 1'b0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
            r_err  <= 1'b0;
        end else begin
            // Lock holds the grant while the device stalls; it drops on the
            // handshake or when the locked host withdraws its request.
            r_lock <= w_fwd & ~tl_d_i.a_ready;
            r_sel  <= w_sel;
            r_cnt0 <= f_cnt_next(r_cnt0, w_a_fire0, w_d_fire0);
            r_cnt1 <= f_cnt_next(r_cnt1, w_a_fire1, w_d_fire1);
            r_err  <= r_err | (w_d_fire0 && (r_cnt0 == '0))
                            | (w_d_fire1 && (r_cnt1 == '0));
        end
    end

`ifdef TLUL_ARB_RR_EN
    // After a grant, the other host becomes preferred.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= 1'b0;
        end else if (w_a_fire0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_a_fire1) begin
            r_rr_ptr <= 1'b0;
        end
    end
`endif

    assign busy_o = (r_cnt0 != '0) | (r_cnt1 != '0);
    assign err_o  = r_err;

endmodule

// File: tb/tb_tlul_host_arb2.sv
// -----------------------------------------------------------------------------
// tb_tlul_host_arb2 -- self-checking bench for tlul_host_arb2
//
// Directed scenarios followed by randomized traffic. A reference model kept as
// integer counters, a lock owner and a queue of outstanding device tags
// predicts every output each cycle. Honors TLUL_ARB_RR_EN.
// -----------------------------------------------------------------------------

module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam int MAX = 2;

    logic    clk;
    logic    rst_n;
    tl_h2d_t h0_i, h1_i, d_o;
    tl_d2h_t h0_o, h1_o, d_i;
    logic    busy_o, err_o;

    tlul_host_arb2 #(.MaxOutstanding(MAX), .SrcW(TL_AIW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .tl_h0_i (h0_i),
        .tl_h0_o (h0_o),
        .tl_h1_i (h1_i),
        .tl_h1_o (h1_o),
        .tl_d_o  (d_o),
        .tl_d_i  (d_i),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    int         m_cnt [2];
    bit         m_err;
    int         m_lock;     // -1: no grant held
    int         m_pref;     // preferred host for round-robin
    logic [7:0] pend[$];    // tags the device still owes a response for

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_err    = 0;
        m_lock   = -1;
        m_pref   = 0;
        pend.delete();
    endtask

    task automatic idle();
        h0_i = '0;
        h1_i = '0;
        d_i  = '0;
    endtask

    task automatic set_host(input int h, input bit v, input logic [6:0] src, input logic [31:0] addr);
        tl_h2d_t r;
        r = (h == 0) ? h0_i : h1_i;
        r.a_valid   = v;
        r.a_opcode  = 3'h4;
        r.a_source  = {1'b0, src};
        r.a_address = addr;
        r.a_mask    = 4'hf;
        if (h == 0) h0_i = r; else h1_i = r;
    endtask

    // Device answers the oldest outstanding request, if any.
    task automatic dev_respond();
        if (pend.size() > 0) begin
            d_i.d_valid  = 1'b1;
            d_i.d_opcode = 3'h1;
            d_i.d_source = pend[0];
            d_i.d_data   = $urandom;
        end else begin
            d_i.d_valid = 1'b0;
        end
    endtask

    // Inputs are set at a negedge; check combinational outputs, advance one
    // clock, update the model and check the registered outputs.
    task automatic step();
        bit      e [2];
        bit      af[2];
        bit      df[2];
        int      w;
        bit      fwd;
        int      t;
        bit      dr_t;
        tl_h2d_t hsel;
        tl_d2h_t hout;
        #1;
        e[0] = h0_i.a_valid && (m_cnt[0] < MAX);
        e[1] = h1_i.a_valid && (m_cnt[1] < MAX);
        if (m_lock >= 0) begin
            w   = m_lock;
            fwd = e[w];
        end else begin
`ifdef TLUL_ARB_RR_EN
            if (e[0] && e[1]) w = m_pref;
            else if (e[0])    w = 0;
            else if (e[1])    w = 1;
            else              w = -1;
`else
            w = e[0] ? 0 : (e[1] ? 1 : -1);
`endif
            fwd = (w >= 0);
        end
        check("d_o.a_valid", d_o.a_valid, fwd);
        if (fwd) begin
            hsel = (w == 0) ? h0_i : h1_i;
            check("d_o.a_source", d_o.a_source, {w[0], hsel.a_source[6:0]});
            check("d_o.a_address", d_o.a_address, hsel.a_address);
        end
        af[0] = fwd && (w == 0) && d_i.a_ready;
        af[1] = fwd && (w == 1) && d_i.a_ready;
        check("h0.a_ready", h0_o.a_ready, af[0]);
        check("h1.a_ready", h1_o.a_ready, af[1]);

        t    = d_i.d_source[7] ? 1 : 0;
        dr_t = (t == 1) ? h1_i.d_ready : h0_i.d_ready;
        check("h0.d_valid", h0_o.d_valid, d_i.d_valid && (t == 0));
        check("h1.d_valid", h1_o.d_valid, d_i.d_valid && (t == 1));
        check("d_o.d_ready", d_o.d_ready, dr_t);
        if (d_i.d_valid) begin
            hout = (t == 1) ? h1_o : h0_o;
            check("h.d_source", hout.d_source, {1'b0, d_i.d_source[6:0]});
            check("h.d_data", hout.d_data, d_i.d_data);
        end
        df[0] = d_i.d_valid && (t == 0) && dr_t;
        df[1] = d_i.d_valid && (t == 1) && dr_t;

        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit dec;
            dec = df[i] && (m_cnt[i] > 0);
            if (df[i] && m_cnt[i] == 0) m_err = 1;
            m_cnt[i] = m_cnt[i] + int'(af[i]) - int'(dec);
        end
        m_lock = (fwd && !d_i.a_ready) ? w : -1;
        if (af[0]) m_pref = 1;
        else if (af[1]) m_pref = 0;
        if ((df[0] || df[1]) && pend.size() > 0 && d_i.d_source == pend[0]) void'(pend.pop_front());
        if (fwd && d_i.a_ready) pend.push_back({w[0], hsel.a_source[6:0]});

        #1;
        check("busy_o", busy_o, (m_cnt[0] != 0) || (m_cnt[1] != 0));
        check("err_o", err_o, m_err);
        @(negedge clk);
    endtask

    task automatic drain();
        h0_i.a_valid = 1'b0;
        h1_i.a_valid = 1'b0;
        h0_i.d_ready = 1'b1;
        h1_i.d_ready = 1'b1;
        for (int k = 0; k < 20 && pend.size() > 0; k++) begin
            dev_respond();
            step();
        end
        check("drain pend", pend.size(), 0);
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #2;
        check("rst busy_o", busy_o, 0);
        check("rst err_o", err_o, 0);
        check("rst d_o.a_valid", d_o.a_valid, 0);
        check("rst h0.a_ready", h0_o.a_ready, 0);
        check("rst h1.d_valid", h1_o.d_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single host-0 Get and its response
        set_host(0, 1, 7'd3, 32'h1000);
        d_i.a_ready = 1'b1;
        #1;
        check("t1 a_source", d_o.a_source, 8'h03);
        check("t1 a_valid", d_o.a_valid, 1);
        step();
        check("t1 busy after A", busy_o, 1);
        h0_i.a_valid = 1'b0;
        h0_i.d_ready = 1'b1;
        d_i.d_valid  = 1'b1;
        d_i.d_opcode = 3'h1;
        d_i.d_source = 8'h03;
        d_i.d_data   = 32'hdeadbeef;
        #1;
        check("t1 h0 d_valid", h0_o.d_valid, 1);
        check("t1 h0 d_source", h0_o.d_source, 8'h03);
        step();
        check("t1 busy after D", busy_o, 0);
        idle();

        // Both hosts requesting back-to-back, device always ready
        d_i.a_ready  = 1'b1;
        h0_i.d_ready = 1'b1;
        h1_i.d_ready = 1'b1;
        set_host(0, 1, 7'd1, 32'h2000);
        set_host(1, 1, 7'd5, 32'h3000);
        for (int i = 0; i < 6; i++) begin
            dev_respond();
            #1;
`ifdef TLUL_ARB_RR_EN
            check("t2 h1 grant", h1_o.a_ready, (i % 2) == 1);
`else
            check("t2 h1 grant", h1_o.a_ready, 0);
`endif
            step();
        end
        drain();

        // Grant lock while the device stalls
        set_host(1, 1, 7'd2, 32'h4000);
        d_i.a_ready = 1'b0;
        step();
        set_host(0, 1, 7'd6, 32'h5000);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3 locked h0 a_ready", h0_o.a_ready, 0);
            check("t3 locked a_source", d_o.a_source, 8'h82);
            step();
        end
        d_i.a_ready = 1'b1;
        #1;
        check("t3 h1 fires", h1_o.a_ready, 1);
        step();
        h1_i.a_valid = 1'b0;
        #1;
        check("t3 h0 fires", h0_o.a_ready, 1);
        step();
        drain();

        // Outstanding limit on host 0
        d_i.a_ready = 1'b1;
        set_host(0, 1, 7'd7, 32'h6000);
        step();
        step();
        set_host(1, 1, 7'd9, 32'h7000);
        #1;
        check("t4 h0 at limit", h0_o.a_ready, 0);
        check("t4 h1 granted", h1_o.a_ready, 1);
        step();
        h1_i.a_valid = 1'b0;
        h0_i.d_ready = 1'b1;
        dev_respond();
        step();
        d_i.d_valid = 1'b0;
        #1;
        check("t4 h0 after D", h0_o.a_ready, 1);
        step();
        drain();

        // Response for a host with nothing outstanding
        h1_i.d_ready = 1'b1;
        d_i.d_valid  = 1'b1;
        d_i.d_source = 8'h85;
        step();
        check("t5 err_o set", err_o, 1);
        check("t5 cnt1 stays 0", busy_o, 0);
        idle();
        step();
        check("t5 err_o sticky", err_o, 1);

        // A and D fire for host 0 in one cycle
        d_i.a_ready = 1'b1;
        h0_i.d_ready = 1'b1;
        set_host(0, 1, 7'd4, 32'h8000);
        step();
        dev_respond();
        step();
        check("t6 cnt0 held", busy_o, 1);
        drain();

        // Reset while a grant is locked
        d_i.a_ready = 1'b1;
        set_host(0, 1, 7'd1, 32'h9000);
        step();
        h0_i.a_valid = 1'b0;
        set_host(1, 1, 7'd3, 32'ha000);
        d_i.a_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7 async busy_o", busy_o, 0);
        check("t7 async err_o", err_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        set_host(0, 1, 7'd2, 32'hb000);
        d_i.a_ready = 1'b1;
        step();
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_host(0, ($urandom_range(0, 9) < 6), 7'($urandom), $urandom);
            set_host(1, ($urandom_range(0, 9) < 6), 7'($urandom), $urandom);
            h0_i.d_ready = ($urandom_range(0, 3) != 0);
            h1_i.d_ready = ($urandom_range(0, 3) != 0);
            d_i.a_ready  = ($urandom_range(0, 9) < 7);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                dev_respond();
            end else begin
                d_i.d_valid  = 1'b0;
                d_i.d_source = 8'($urandom);
            end
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
